// File: rtl/bcd_code_encoder.sv
// rtl/bcd_code_encoder.sv - glyph-code stream to packed-BCD word encoder
// Define RANGE_CHECK_EN to reject assembled words greater than limit.
module bcd_code_encoder #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              sel_in,
  input  logic [1:0]              addr_in,
  input  logic [4*NUM_DIGITS-1:0] limit,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    err_code,
  output logic                    err_range,
  output logic [2:0]              digit_cnt
);
  localparam int W = 4 * NUM_DIGITS;
  localparam logic [2:0] LAST_CNT = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {COLLECT, CHECK, HOLD} state_t;

  state_t       state;
  logic [W-1:0] acc;
  logic         code_legal;
  logic [3:0]   digit;
  logic         range_ok;
  logic         err_range_q;

  // Selects 4/5/6 carry digits in groups of four; select 6 only holds 8 and 9.
  assign code_legal = (sel_in == 4'd4) || (sel_in == 4'd5) ||
                      ((sel_in == 4'd6) && !addr_in[1]);
  assign digit      = {sel_in[1:0], addr_in};
  assign in_ready   = (state == COLLECT) && !reset;

`ifdef RANGE_CHECK_EN
  assign range_ok  = (acc <= limit);
  assign err_range = err_range_q;
`else
  logic unused_bits;
  assign unused_bits = ^{limit, err_range_q};
  assign range_ok    = 1'b1;
  assign err_range   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      acc         <= '0;
      bcd_out     <= '0;
      out_valid   <= 1'b0;
      err_code    <= 1'b0;
      err_range_q <= 1'b0;
      digit_cnt   <= '0;
    end else begin
      err_code    <= 1'b0;
      err_range_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (abort) begin
            acc       <= '0;
            digit_cnt <= '0;
          end else if (in_valid) begin
            if (!code_legal) begin
              err_code  <= 1'b1;
              acc       <= '0;
              digit_cnt <= '0;
            end else begin
              acc <= W'({acc, digit});
              if (digit_cnt == LAST_CNT) begin
                digit_cnt <= '0;
                state     <= CHECK;
              end else begin
                digit_cnt <= digit_cnt + 3'd1;
              end
            end
          end
        end
        CHECK: begin
          acc <= '0;
          if (range_ok) begin
            bcd_out   <= acc;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            err_range_q <= 1'b1;
            state       <= COLLECT;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_code_encoder.sv
// tb/tb_bcd_code_encoder.sv - self-checking bench for bcd_code_encoder
// Honours RANGE_CHECK_EN when it is defined for the whole build.
module tb_bcd_code_encoder;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   sel_in = 4'd0;
  logic [1:0]   addr_in = 2'd0;
  logic [7:0]   limit = 8'h59;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   bcd_out;
  logic         err_code;
  logic         err_range;
  logic [2:0]   digit_cnt;

  int tests = 0;
  int fails = 0;
  bit run_chk = 1'b0;
  int err_code_seen = 0;

  bcd_code_encoder #(.NUM_DIGITS(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sel_in(sel_in), .addr_in(addr_in), .limit(limit), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out),
    .err_code(err_code), .err_range(err_range), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digits held as a list of integers, word packed arithmetically.
  int         m_digits[$];
  bit         m_checking = 1'b0;
  bit         m_hold = 1'b0;
  bit         m_err_code = 1'b0;
  bit         m_err_range = 1'b0;
  logic [7:0] m_word = 8'h00;
  logic [7:0] m_bcd = 8'h00;

  function automatic int glyph_digit(input logic [3:0] s, input logic [1:0] a);
    for (int d = 0; d < 10; d++)
      if (int'(s) == 4 + d / 4 && int'(a) == d % 4) return d;
    return -1;
  endfunction

  function automatic bit word_in_range(input logic [7:0] w, input logic [7:0] lim);
`ifdef RANGE_CHECK_EN
    return int'(w) <= int'(lim);
`else
    return 1'b1;
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_digits.delete();
      m_checking = 1'b0; m_hold = 1'b0; m_err_code = 1'b0; m_err_range = 1'b0;
      m_word = 8'h00; m_bcd = 8'h00;
    end else begin
      m_err_code = 1'b0;
      m_err_range = 1'b0;
      if (m_hold) begin
        if (out_ready) m_hold = 1'b0;
      end else if (m_checking) begin
        m_checking = 1'b0;
        if (word_in_range(m_word, limit)) begin
          m_hold = 1'b1;
          m_bcd = m_word;
        end else begin
          m_err_range = 1'b1;
        end
      end else if (abort) begin
        m_digits.delete();
      end else if (in_valid) begin
        int d;
        d = glyph_digit(sel_in, addr_in);
        if (d < 0) begin
          m_err_code = 1'b1;
          m_digits.delete();
        end else begin
          m_digits.push_back(d);
          if (m_digits.size() == N) begin
            int w;
            w = 0;
            foreach (m_digits[i]) w = w * 16 + m_digits[i];
            m_word = 8'(w);
            m_checking = 1'b1;
            m_digits.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("m_in_ready", in_ready, !reset && !m_hold && !m_checking);
      chk("m_out_valid", out_valid, m_hold);
      chk("m_bcd_out", bcd_out, m_bcd);
      chk("m_err_code", err_code, m_err_code);
      chk("m_err_range", err_range, m_err_range);
      chk("m_digit_cnt", digit_cnt, m_digits.size());
      if (err_code === 1'b1) err_code_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] s, input logic [1:0] a);
    in_valid = 1'b1; sel_in = s; addr_in = a;
    step();
    in_valid = 1'b0; sel_in = 4'd0; addr_in = 2'd0;
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    step();
    step();
    run_chk = 1'b1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bcd_out", bcd_out, 0);
    chk("rst_digit_cnt", digit_cnt, 0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // 5,9 at the inclusive limit
    limit = 8'h59;
    send(4'd5, 2'd1);
    send(4'd6, 2'd1);
    chk("t1_check_cycle_valid", out_valid, 0);
    chk("t1_check_cycle_ready", in_ready, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_bcd_out", bcd_out, 8'h59);
    release_word();
    chk("t1_released", out_valid, 0);
    chk("t1_ready_again", in_ready, 1);

    // 9,0 exceeds 0x59
    send(4'd6, 2'd1);
    send(4'd4, 2'd0);
    step();
`ifdef RANGE_CHECK_EN
    chk("t2_err_range", err_range, 1);
    chk("t2_no_valid", out_valid, 0);
    step();
    chk("t2_err_range_pulse", err_range, 0);
`else
    chk("t2_out_valid", out_valid, 1);
    chk("t2_bcd_out", bcd_out, 8'h90);
    release_word();
`endif
    send(4'd4, 2'd3);
    send(4'd4, 2'd2);
    step();
    chk("t2_next_bcd", bcd_out, 8'h32);
    release_word();

    // illegal codes
    send(4'd6, 2'd2);
    chk("t3_err_code_a", err_code, 1);
    chk("t3_cnt_a", digit_cnt, 0);
    step();
    chk("t3_err_code_a_pulse", err_code, 0);
    send(4'd0, 2'd0);
    chk("t3_err_code_b", err_code, 1);
    step();
    chk("t3_cnt_b", digit_cnt, 0);
    send(4'd4, 2'd1);
    send(4'd4, 2'd0);
    step();
    chk("t3_bcd_out", bcd_out, 8'h10);

    // held word ignores input while the consumer stalls
    release_word();
    send(4'd4, 2'd1);
    send(4'd5, 2'd2);
    step();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); sel_in = 4'd4; addr_in = 2'd0;
      step();
      chk("t4_bcd_stable", bcd_out, 8'h16);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_cnt", digit_cnt, 0);
    end
    in_valid = 1'b0;
    release_word();
    chk("t4_back_collect", in_ready, 1);

    // abort beats a concurrent code
    err_code_seen = 0;
    send(4'd5, 2'd0);
    chk("t5_cnt_one", digit_cnt, 1);
    abort = 1'b1; in_valid = 1'b1; sel_in = 4'd4; addr_in = 2'd3;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("t5_cnt_cleared", digit_cnt, 0);
    send(4'd4, 2'd2);
    send(4'd5, 2'd1);
    step();
    chk("t5_bcd_out", bcd_out, 8'h25);
    chk("t5_no_err_code", err_code_seen, 0);

    // reset while holding, then mid-word
    limit = 8'h23;
    release_word();
    send(4'd4, 2'd2);
    send(4'd4, 2'd3);
    step();
    chk("t6_equal_limit_valid", out_valid, 1);
    chk("t6_equal_limit_bcd", bcd_out, 8'h23);
    reset = 1'b1;
    step();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_bcd", bcd_out, 0);
    chk("t6_rst_cnt", digit_cnt, 0);
    chk("t6_rst_ready", in_ready, 0);
    reset = 1'b0;
    step();
    chk("t6_ready_after", in_ready, 1);
    send(4'd5, 2'd0);
    chk("t6_mid_cnt", digit_cnt, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_mid_cnt_cleared", digit_cnt, 0);
    send(4'd4, 2'd2);
    send(4'd5, 2'd0);
    step();
`ifdef RANGE_CHECK_EN
    chk("t6_over_limit_err", err_range, 1);
    chk("t6_over_limit_novalid", out_valid, 0);
    step();
`else
    chk("t6_over_limit_bcd", bcd_out, 8'h24);
    release_word();
`endif
    step();
    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
